// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK-flip-flop based synchronous counter.
//   jk_code_t      : JK excitation code, packed as {j,k}
//   jk_next_exc()  : per-bit excitation selection (reset > load > count > hold)
//   jk_terminal()  : terminal-count decode for the current count and controls
//   jk_apply()     : JK flip-flop characteristic equation
// -----------------------------------------------------------------------------
package jk_pkg;

  // Excitation codes, bit 1 = j, bit 0 = k.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_code_t;

  // Excitation for one bit. ones_below/zeros_below tell whether every
  // lower-order bit is 1 (resp. 0); for bit 0 both are tied high so the
  // least significant bit toggles on every counting edge.
  function automatic jk_code_t jk_next_exc(
    input logic rst,
    input logic load,
    input logic en,
    input logic up,
    input logic d_bit,
    input logic ones_below,
    input logic zeros_below
  );
    jk_code_t code;
    code = JK_HOLD;
    if (rst) begin
      code = JK_RESET;
    end else if (load) begin
      code = d_bit ? JK_SET : JK_RESET;
    end else if (en) begin
      if (up) begin
        code = ones_below ? JK_TOGGLE : JK_HOLD;
      end else begin
        code = zeros_below ? JK_TOGGLE : JK_HOLD;
      end
    end else begin
      code = JK_HOLD;
    end
    return code;
  endfunction

  // Terminal count: high only when the next counting edge wraps around.
  function automatic logic jk_terminal(
    input logic rst,
    input logic load,
    input logic en,
    input logic up,
    input logic all_ones,
    input logic all_zeros
  );
    return en & ~load & ~rst & ((up & all_ones) | (~up & all_zeros));
  endfunction

  // Next flip-flop state for a given excitation and present state.
  function automatic logic jk_apply(input jk_code_t code, input logic cur);
    logic nxt;
    case (code)
      JK_HOLD:   nxt = cur;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~cur;
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// -----------------------------------------------------------------------------
// jk_ff
// Single rising-edge JK flip-flop. No reset path of its own: clearing is done
// by driving the JK_RESET excitation from the surrounding logic.
//   j, k : excitation inputs
//   clk  : rising-edge clock
//   q    : stored bit
// -----------------------------------------------------------------------------
module jk_ff
  import jk_pkg::*;
(
  input  logic j,
  input  logic k,
  input  logic clk,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next state from the JK characteristic equation.
  always_comb begin
    q_d = jk_apply(jk_code_t'({j, k}), q_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// -----------------------------------------------------------------------------
// jk_sync_counter
// Synchronous up/down counter with parallel load, built from WIDTH JK
// flip-flops. The only storage is the jk_ff bank; all excitation and the
// terminal-count output are combinational from q and the inputs.
//   WIDTH : counter width (2..16)
//   clk   : rising-edge clock
//   rst   : synchronous active-high clear (highest priority)
//   en    : count enable
//   up    : 1 = increment, 0 = decrement
//   load  : synchronous parallel load of d (beats en)
//   d     : parallel-load value
//   q     : current count, straight from the flip-flop outputs
//   tc    : terminal count, high in the cycle before a wrap
// -----------------------------------------------------------------------------
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] q_ff;
  logic [WIDTH-1:0] ones_below;
  logic [WIDTH-1:0] zeros_below;
  jk_code_t         exc [WIDTH];

  // Prefix AND of the lower-order bits: a bit toggles when counting up
  // only if everything below it is 1, and counting down if everything is 0.
  always_comb begin : prefix_calc
    logic all1;
    logic all0;
    all1        = 1'b1;
    all0        = 1'b1;
    ones_below  = '0;
    zeros_below = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_below[i]  = all1;
      zeros_below[i] = all0;
      all1 = all1 & q_ff[i];
      all0 = all0 & ~q_ff[i];
    end
  end

  // Per-bit excitation selection.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      exc[i] = jk_next_exc(rst, load, en, up, d[i], ones_below[i], zeros_below[i]);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_ff u_ff (
      .j   (exc[g][1]),
      .k   (exc[g][0]),
      .clk (clk),
      .q   (q_ff[g])
    );
  end

  assign q  = q_ff;
  assign tc = jk_terminal(rst, load, en, up, &q_ff, ~|q_ff);

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 clk  input  1  Rising-edge clock; the only clock.
REQ-003 rst  input  1  Reset, synchronous, active-high.
REQ-004 en  input  1  Count enable.
REQ-005 up  input  1  Direction: 1 = increment, 0 = decrement.
REQ-006 load  input  1  Synchronous parallel-load request.
REQ-007 d  input  WIDTH  Parallel-load value.
REQ-008 q  output  WIDTH  Current count; taken directly from the per-bit JK flip-flop outputs.
REQ-009 tc  output  1  Terminal count, combinational.

Function
REQ-010 Every clock edge, each bit i SHALL be driven through a jk_ff by an excitation pair (j[i],k[i]); q SHALL change only on rising clk.
REQ-011 Priority per edge SHALL be rst > load > en > hold.
REQ-012 rst=1: j[i]=0, k[i]=1 for all i; after the edge q = 0.
REQ-013 load=1 (rst=0): j[i]=d[i], k[i]=~d[i]; after the edge q = d; en and up are ignored.
REQ-014 en=1, up=1 (rst=0, load=0): j[i]=k[i]=1 iff q[i-1:0] are all 1 (bit 0 always toggles); otherwise j[i]=k[i]=0.
REQ-015 en=1, up=0: j[i]=k[i]=1 iff q[i-1:0] are all 0 (bit 0 always toggles); otherwise j[i]=k[i]=0.
REQ-016 en=0, load=0, rst=0: j=k=0 on all bits; q holds.
REQ-017 Counting SHALL be modulo 2^WIDTH: up from all-ones wraps to 0; down from 0 wraps to all-ones, with no extra cycle.
REQ-018 tc = en & ~load & ~rst & ((up & q==all-ones) | (~up & q==0)); tc is therefore high exactly in the cycle before a wrap.
REQ-019 Changing up mid-count SHALL take effect at the next edge with no lost or extra count.
REQ-020 load and en asserted together SHALL load d; counting resumes from d on the following edge if en remains high.
REQ-021 rst asserted mid-count or mid-load SHALL clear q at that edge regardless of other inputs.

Reset
REQ-022 Reset is synchronous only; asynchronous clear/preset paths are prohibited.
REQ-023 Reset value: q = 0 one edge after rst is sampled high; tc = 0 while rst = 1.
REQ-024 Before the first rst edge, q is undefined (X in simulation); a bench SHALL apply rst for at least one clk edge before checking outputs.

Structure
REQ-025 The shared package jk_pkg SHALL hold the JK excitation codes {j,k}: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
REQ-026 The excitation logic SHALL be a combinational next-excitation function selecting one jk_pkg code per bit.
REQ-027 One sub-module type, the existing jk_ff (ports j, k, clk, q), SHALL be instantiated WIDTH times via generate; there SHALL be no other storage elements.
REQ-028 tc and all excitation logic SHALL be combinational from q and the inputs; the block SHALL add no extra register stage.

Verification (WIDTH=4, clk period 10)
REQ-029 rst=1 for 1 edge, then en=1, up=1 for 18 edges -> q = 0,1,...,15,0,1; tc=1 only while q=15.
REQ-030 load=1, d=4'hA for 1 edge, then en=1, up=0 for 12 edges -> q = A,9,...,0,F; tc=1 only while q=0.
REQ-031 q=7, en=0 for 5 edges with up toggling -> q stays 7; tc=0.
REQ-032 q=3, load=1, en=1, up=1, d=4'hC -> q=C; next edge with load=0 -> q=D.
REQ-033 q=9, rst=1 together with load=1, en=1, d=5 -> q=0 after that edge; tc=0 while rst=1.
REQ-034 Counting up, flip up at q=14 -> next q=13, no skipped value; check {j,k} per bit against jk_pkg codes every cycle.
